// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the instruction-fetch slice: fetch FSM encoding,
// reset PC and instruction width/step constants.
package instr_fetch_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned WAIT_CNT_W   = 8;
   localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] INSTR_STEP   = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_fsm.sv
// Fetch control FSM: owns the state, the kill flag for in-flight redirects and
// the imem_ack wait counter; drives the registered req/valid outputs.
module fetch_fsm
   import instr_fetch_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_imem_ack,
   input  logic         i_redirect,
   input  logic         i_instr_ready,
   output fetch_state_t o_state,
   output logic         o_kill,
   output logic         o_imem_req,
   output logic         o_instr_valid,
   output logic         o_capture,
   output logic         o_timeout
);

   localparam logic [WAIT_CNT_W-1:0] LP_LAST_WAIT = WAIT_CNT_W'(ACK_TIMEOUT - 1);

   fetch_state_t          r_state;
   logic                  r_kill;
   logic [WAIT_CNT_W-1:0] r_cnt;
   logic                  r_imem_req;
   logic                  r_instr_valid;
   logic                  w_in_req;
   logic                  w_timeout;
   logic                  w_capture;

   assign w_in_req  = (r_state == ST_REQ);
   // The cycle holding the last allowed wait is itself the timeout cycle.
   assign w_timeout = w_in_req & ~i_imem_ack & (r_cnt == LP_LAST_WAIT);
   assign w_capture = w_in_req & i_imem_ack & ~i_redirect & ~r_kill;

   // State, kill flag, wait counter and registered handshake outputs.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state       <= ST_IDLE;
         r_kill        <= 1'b0;
         r_cnt         <= '0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state       <= ST_REQ;
               r_kill        <= 1'b0;
               r_cnt         <= '0;
               r_imem_req    <= 1'b1;
               r_instr_valid <= 1'b0;
            end
            ST_REQ: begin
               if (i_imem_ack) begin
                  r_kill <= 1'b0;
                  r_cnt  <= '0;
                  if (i_redirect || r_kill) begin
                     r_state       <= ST_REQ;
                     r_imem_req    <= 1'b1;
                     r_instr_valid <= 1'b0;
                  end else begin
                     r_state       <= ST_HOLD;
                     r_imem_req    <= 1'b0;
                     r_instr_valid <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_state       <= ST_IDLE;
                  r_kill        <= 1'b0;
                  r_cnt         <= '0;
                  r_imem_req    <= 1'b0;
                  r_instr_valid <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + WAIT_CNT_W'(1);
                  if (i_redirect) begin
                     r_kill <= 1'b1;
                  end else begin
                     r_kill <= r_kill;
                  end
               end
            end
            ST_HOLD: begin
               if (i_redirect || i_instr_ready) begin
                  r_state       <= ST_REQ;
                  r_cnt         <= '0;
                  r_imem_req    <= 1'b1;
                  r_instr_valid <= 1'b0;
               end else begin
                  r_state       <= ST_HOLD;
                  r_instr_valid <= 1'b1;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_kill        <= 1'b0;
               r_cnt         <= '0;
               r_imem_req    <= 1'b0;
               r_instr_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_state       = r_state;
   assign o_kill        = r_kill;
   assign o_imem_req    = r_imem_req;
   assign o_instr_valid = r_instr_valid;
   assign o_capture     = w_capture;
   assign o_timeout     = w_timeout;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: computes the next PC for the external PC register,
// talks to instruction memory and presents fetched words to decode.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter logic [31:0] RESET_PC    = CPU_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_addr,
   output logic [31:0] new_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        fetch_err
);

   fetch_state_t w_state;
   logic         w_kill;
   logic         w_capture;
   logic         w_timeout;
   logic         w_req_done;
   logic [31:0]  w_redir_pc;
   logic [31:0]  w_next_pc;
   logic [31:0]  r_target;
   logic [31:0]  r_instr;
   logic [31:0]  r_instr_pc;
   logic         r_fetch_err;

   fetch_fsm #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_imem_ack    (imem_ack),
      .i_redirect    (redirect),
      .i_instr_ready (instr_ready),
      .o_state       (w_state),
      .o_kill        (w_kill),
      .o_imem_req    (imem_req),
      .o_instr_valid (instr_valid),
      .o_capture     (w_capture),
      .o_timeout     (w_timeout)
   );

   assign w_redir_pc = align_pc(redirect_target);
   assign w_req_done = imem_ack | w_timeout;

   // Next-PC select; the PC register samples this every clock, so it must be combinational.
   always_comb begin
      w_next_pc = pc_addr;
      case (w_state)
         ST_IDLE: begin
            if (redirect) w_next_pc = w_redir_pc;
            else          w_next_pc = pc_addr;
         end
         ST_REQ: begin
            if (w_req_done && redirect)    w_next_pc = w_redir_pc;
            else if (w_req_done && w_kill) w_next_pc = r_target;
            else                           w_next_pc = pc_addr;
         end
         ST_HOLD: begin
            if (redirect)         w_next_pc = w_redir_pc;
            else if (instr_ready) w_next_pc = pc_addr + INSTR_STEP;
            else                  w_next_pc = pc_addr;
         end
         default: w_next_pc = pc_addr;
      endcase
   end

   assign new_pc    = rst_n ? RESET_PC : w_next_pc;
   assign imem_addr = pc_addr;

   // Datapath: saved redirect target, captured instruction and sticky error.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_target    <= 32'h0000_0000;
         r_instr     <= 32'h0000_0000;
         r_instr_pc  <= 32'h0000_0000;
         r_fetch_err <= 1'b0;
      end else begin
         if ((w_state == ST_REQ) && redirect && !w_req_done) begin
            r_target <= w_redir_pc;
         end else begin
            r_target <= r_target;
         end
         if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= pc_addr;
         end else begin
            r_instr    <= r_instr;
            r_instr_pc <= r_instr_pc;
         end
         r_fetch_err <= r_fetch_err | w_timeout;
      end
   end

   assign instr     = r_instr;
   assign instr_pc  = r_instr_pc;
   assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with an external PC register model.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_addr;
   logic [31:0] new_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        fetch_err;

   int n_cmp  = 0;
   int n_fail = 0;

   instr_fetch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_addr         (pc_addr),
      .new_pc          (new_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .fetch_err       (fetch_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // PC register model: loads new_pc every clock, resets to the reset PC.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) pc_addr <= 32'h0000_3000;
      else       pc_addr <= new_pc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      #3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held_instr;
      logic [31:0] held_pc;
      logic        req_all_high;

      rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
      redirect_target = 32'h0; instr_ready = 1'b0;
      #1;
      chk("rst_new_pc", new_pc, 32'h0000_3000);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      nxt(); nxt();

      // Reset release: one IDLE cycle, then REQ at the reset PC.
      rst_n = 1'b0;
      smp();
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      chk("idle_new_pc", new_pc, 32'h0000_3000);
      nxt(); smp();
      chk("req_on", {31'd0, imem_req}, 32'd1);
      chk("req_addr", imem_addr, 32'h0000_3000);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'h2008_0001;
      smp();
      chk("ack_new_pc", new_pc, 32'h0000_3000);
      chk("ack_valid", {31'd0, instr_valid}, 32'd0);
      nxt();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      smp();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instr, 32'h2008_0001);
      chk("hold_pc", instr_pc, 32'h0000_3000);
      chk("hold_req", {31'd0, imem_req}, 32'd0);

      // Decode stalls for five cycles: everything must hold.
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_instr", instr, 32'h2008_0001);
         chk("stall_pc", instr_pc, 32'h0000_3000);
         chk("stall_new_pc", new_pc, 32'h0000_3000);
         nxt(); smp();
      end
      instr_ready = 1'b1;
      smp();
      chk("ready_new_pc", new_pc, 32'h0000_3004);
      nxt();
      instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
      smp();
      chk("lat_req", {31'd0, imem_req}, 32'd1);
      chk("lat_addr", imem_addr, 32'h0000_3004);
      chk("lat_valid_low", {31'd0, instr_valid}, 32'd0);
      nxt();
      imem_ack = 1'b0; instr_ready = 1'b1;
      smp();
      chk("lat_valid", {31'd0, instr_valid}, 32'd1);
      chk("lat_instr", instr, 32'h0000_0013);
      chk("lat_pc", instr_pc, 32'h0000_3004);
      chk("lat_new_pc", new_pc, 32'h0000_3008);
      nxt();

      // Redirect while the request is outstanding; the late data is dropped.
      instr_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_3107;
      smp();
      chk("kill_new_pc", new_pc, 32'h0000_3008);
      nxt();
      redirect = 1'b0;
      smp();
      chk("kill_req", {31'd0, imem_req}, 32'd1);
      chk("kill_addr", imem_addr, 32'h0000_3008);
      nxt(); smp();
      chk("kill_wait_valid", {31'd0, instr_valid}, 32'd0);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      smp();
      chk("kill_ack_new_pc", new_pc, 32'h0000_3104);
      nxt();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      redirect = 1'b1; redirect_target = 32'h0000_3300;
      smp();
      chk("kill_drop_valid", {31'd0, instr_valid}, 32'd0);
      chk("kill_drop_instr", instr, 32'h0000_0013);
      chk("kill_next_addr", imem_addr, 32'h0000_3104);
      chk("kill_next_req", {31'd0, imem_req}, 32'd1);
      nxt();
      redirect_target = 32'h0000_3404;
      smp();
      nxt();
      redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      smp();
      chk("last_wins_new_pc", new_pc, 32'h0000_3404);
      nxt();

      // Redirect coinciding with ack: data dropped, aligned target taken.
      redirect = 1'b1; redirect_target = 32'h0000_3501; imem_rdata = 32'h2222_2222;
      smp();
      chk("lw_addr", imem_addr, 32'h0000_3404);
      chk("redir_ack_new_pc", new_pc, 32'h0000_3500);
      nxt();
      redirect = 1'b0; imem_rdata = 32'h0000_0093;
      smp();
      chk("redir_ack_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_ack_addr", imem_addr, 32'h0000_3500);
      nxt();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      redirect = 1'b1; redirect_target = 32'h0000_3200; instr_ready = 1'b1;
      smp();
      chk("f3_instr", instr, 32'h0000_0093);
      chk("f3_pc", instr_pc, 32'h0000_3500);
      chk("redir_ready_new_pc", new_pc, 32'h0000_3200);
      nxt();
      redirect = 1'b0; instr_ready = 1'b0;
      smp();
      chk("redir_ready_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_ready_addr", imem_addr, 32'h0000_3200);

      // Steer to the top of the address space and check the PC wrap.
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFF; imem_ack = 1'b1;
      smp();
      chk("top_new_pc", new_pc, 32'hFFFF_FFFC);
      nxt();
      redirect = 1'b0; imem_rdata = 32'h0000_0073;
      smp();
      nxt();
      imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b1;
      smp();
      chk("top_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_new_pc", new_pc, 32'h0000_0000);
      nxt();
      instr_ready = 1'b0;
      smp();
      chk("wrap_addr", imem_addr, 32'h0000_0000);

      // No ack: request stays up for exactly 255 cycles, then a timeout.
      req_all_high = 1'b1;
      for (int i = 0; i < 255; i++) begin
         if (imem_req !== 1'b1) req_all_high = 1'b0;
         nxt(); smp();
      end
      chk("to_req_held", {31'd0, req_all_high}, 32'd1);
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("to_req_drop", {31'd0, imem_req}, 32'd0);
      chk("to_new_pc", new_pc, 32'h0000_0000);
      nxt(); smp();
      chk("retry_req", {31'd0, imem_req}, 32'd1);
      chk("retry_addr", imem_addr, 32'h0000_0000);
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      for (int i = 0; i < 10; i++) nxt();

      // Asynchronous reset in the middle of the wait.
      rst_n = 1'b1;
      #1;
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_rst_instr", instr, 32'd0);
      chk("mid_rst_pc", instr_pc, 32'd0);
      chk("mid_rst_err", {31'd0, fetch_err}, 32'd0);
      chk("mid_rst_new_pc", new_pc, 32'h0000_3000);
      nxt();
      rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      smp();
      chk("late_ack_req", {31'd0, imem_req}, 32'd0);
      nxt();
      imem_ack = 1'b0;
      smp();
      chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
      chk("late_ack_instr", instr, 32'd0);
      chk("late_ack_restart", {31'd0, imem_req}, 32'd1);
      chk("late_ack_addr", imem_addr, 32'h0000_3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
